// File: rtl/rv32_imm_gen_pipe.sv
// rv32_imm_gen_pipe
//   Decodes the immediate field and instruction format of a raw RV32
//   instruction. The decoded result sits in a one-stage valid/ready
//   pipeline, and a sideband tag travels with each instruction.
//
// Parameters
//   XLEN   immediate width (32 or 64)
//   TAG_W  sideband tag width
//   CNT_W  illegal-instruction counter width (saturating)
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   in_valid/in_ready  input handshake
//   in_instr, in_tag   instruction word and its tag
//   out_valid/out_ready output handshake
//   out_imm            decoded immediate, sign-extended to XLEN
//   out_fmt            0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 illegal
//   out_tag            tag of the instruction on out_*
//   illegal_cnt        number of format-7 instructions delivered downstream
//
// Configuration
//   PITO_IMM_SKID_EN   when defined, in_ready comes from a register and a
//                      2-entry buffer (output register + skid entry)
//                      absorbs the in-flight instruction. When undefined,
//                      there is a single output register and in_ready is
//                      combinational.
module rv32_imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_Z   = 3'd6,
    FMT_ILL = 3'd7
  } fmt_e;

  // Decode
  // The immediate is built as 32 bits and then sign-extended to XLEN.
  // Z and R values have bit 31 clear, so the same extension leaves them
  // zero-extended.
  logic [31:0]     dec_imm32;
  fmt_e            dec_fmt;
  logic [XLEN-1:0] dec_imm;

  always_comb begin
    dec_fmt   = FMT_ILL;
    dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
    // Every legal opcode ends in 2'b11, so instructions whose low bits are
    // not 2'b11 fall through to the default (illegal) case.
    case (in_instr[6:0])
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111: dec_fmt = FMT_I;
      7'b1110011: begin
        dec_fmt   = FMT_Z;
        dec_imm32 = {27'd0, in_instr[19:15]};
      end
      7'b0100011: begin
        dec_fmt   = FMT_S;
        dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec_fmt   = FMT_B;
        dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt   = FMT_U;
        dec_imm32 = {in_instr[31:12], 12'd0};
      end
      7'b1101111: begin
        dec_fmt   = FMT_J;
        dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b0110011, 7'b0111011, 7'b0011011: begin
        dec_fmt   = FMT_R;
        dec_imm32 = '0;
      end
      default: ;
    endcase
  end

  assign dec_imm = XLEN'($signed(dec_imm32));

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

`ifdef PITO_IMM_SKID_EN
  // The output register is the head entry and the skid register is the
  // second entry. in_ready is registered, so it is computed from the
  // occupancy the buffer will have after this edge: it drops only when
  // both entries will be full.
  logic             rdy_q;
  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  fmt_e             skid_fmt;
  logic [TAG_W-1:0] skid_tag;

  assign in_ready = rdy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_imm    <= '0;
      out_fmt    <= FMT_R;
      out_tag    <= '0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_fmt   <= FMT_R;
      skid_tag   <= '0;
      rdy_q      <= 1'b1;
    end else begin
      if (out_fire) begin
        if (skid_valid) begin
          // The buffer is full here, so in_ready is low and no push can
          // happen in the same cycle.
          out_imm    <= skid_imm;
          out_fmt    <= skid_fmt;
          out_tag    <= skid_tag;
          skid_valid <= 1'b0;
        end else if (in_fire) begin
          out_imm <= dec_imm;
          out_fmt <= dec_fmt;
          out_tag <= in_tag;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (in_fire) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
          out_imm   <= dec_imm;
          out_fmt   <= dec_fmt;
          out_tag   <= in_tag;
        end else begin
          skid_valid <= 1'b1;
          skid_imm   <= dec_imm;
          skid_fmt   <= dec_fmt;
          skid_tag   <= in_tag;
        end
      end
      rdy_q <= !((skid_valid && !out_fire) ||
                 (out_valid && in_fire && !out_fire));
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_imm   <= '0;
      out_fmt   <= FMT_R;
      out_tag   <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_imm <= dec_imm;
        out_fmt <= dec_fmt;
        out_tag <= in_tag;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_cnt <= '0;
    end else if (out_fire && (out_fmt == FMT_ILL) && (illegal_cnt != '1)) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rv32_imm_gen_pipe.sv
// Testbench for rv32_imm_gen_pipe. It drives two instances with the same
// stimulus: XLEN=32 with the default counter width, and XLEN=64 with
// CNT_W=2. The expected values come from a table of hand-decoded
// instructions.
module tb_rv32_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        rdy_a, ov_a;
  logic [31:0] imm_a;
  logic [2:0]  fmt_a;
  logic [4:0]  tag_a;
  logic [15:0] cnt_a;

  logic        rdy_b, ov_b;
  logic [63:0] imm_b;
  logic [2:0]  fmt_b;
  logic [4:0]  tag_b;
  logic [1:0]  cnt_b;

  always #5 clk = ~clk;

  rv32_imm_gen_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(16)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(ov_a),
    .out_ready(out_ready), .out_imm(imm_a), .out_fmt(fmt_a),
    .out_tag(tag_a), .illegal_cnt(cnt_a)
  );

  rv32_imm_gen_pipe #(.XLEN(64), .TAG_W(5), .CNT_W(2)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(ov_b),
    .out_ready(out_ready), .out_imm(imm_b), .out_fmt(fmt_b),
    .out_tag(tag_b), .illegal_cnt(cnt_b)
  );

`ifdef PITO_IMM_SKID_EN
  localparam int EXP_ACC = 2;
`else
  localparam int EXP_ACC = 1;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [63:0] imm;
  } vec_t;

  vec_t vecs[15];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_ov_a", 64'(ov_a), 0);   chk("rst_ov_b", 64'(ov_b), 0);
    chk("rst_imm_a", 64'(imm_a), 0); chk("rst_imm_b", imm_b, 0);
    chk("rst_fmt_a", 64'(fmt_a), 0); chk("rst_fmt_b", 64'(fmt_b), 0);
    chk("rst_tag_a", 64'(tag_a), 0); chk("rst_tag_b", 64'(tag_b), 0);
    chk("rst_cnt_a", 64'(cnt_a), 0); chk("rst_cnt_b", 64'(cnt_b), 0);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Streams table entries 0..7 tagged 0..7. When rnd is set, out_ready is
  // chosen at random each cycle. At every cycle where an output is
  // presented, the tag and immediate must be those of the next instruction
  // still owed, so a stalled output may not change.
  task automatic stream(input bit rnd, output int cycles);
    int  sent, got;
    bit  fire;
    sent = 0; got = 0; cycles = 0;
    in_valid  = 1'b1;
    in_tag    = 5'd0;
    in_instr  = vecs[0].instr;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (got < 8 && cycles < 300) begin
      @(negedge clk);
      fire = in_valid && rdy_b;
      if (ov_b) begin
        chk("strm_tag_b", 64'(tag_b), 64'(got));
        chk("strm_imm_b", imm_b, vecs[got].imm);
        chk("strm_tag_a", 64'(tag_a), 64'(got));
        if (out_ready) got++;
      end
      if (fire) sent++;
      @(posedge clk);
      #1;
      cycles++;
      in_valid  = (sent < 8);
      in_tag    = 5'(sent);
      in_instr  = vecs[sent % 8].instr;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    chk("strm_delivered", 64'(got), 8);
    in_valid = 1'b0;
  endtask

  initial begin
    int nill;
    int cyc;
    int n;
    int got;
    bit fire;

    vecs[0]  = '{32'hFFF00093, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF}; // addi -1
    vecs[1]  = '{32'h800000B7, 3'd4, 64'hFFFF_FFFF_8000_0000}; // lui
    vecs[2]  = '{32'hFE000EE3, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC}; // beq -4
    vecs[3]  = '{32'h3402D073, 3'd6, 64'h0000_0000_0000_0005}; // csrrwi 5
    vecs[4]  = '{32'h00000000, 3'd7, 64'h0000_0000_0000_0000}; // illegal
    vecs[5]  = '{32'hFE512C23, 3'd2, 64'hFFFF_FFFF_FFFF_FFF8}; // sw -8
    vecs[6]  = '{32'h403100B3, 3'd0, 64'h0000_0000_0000_0000}; // sub
    vecs[7]  = '{32'h001000EF, 3'd5, 64'h0000_0000_0000_0800}; // jal +2048
    vecs[8]  = '{32'h12345017, 3'd4, 64'h0000_0000_1234_5000}; // auipc
    vecs[9]  = '{32'h7FF12083, 3'd1, 64'h0000_0000_0000_07FF}; // lw 0x7ff
    vecs[10] = '{32'hFFF00092, 3'd7, 64'hFFFF_FFFF_FFFF_FFFF}; // low bits 10
    vecs[11] = '{32'h8000007F, 3'd7, 64'hFFFF_FFFF_FFFF_F800}; // bad opcode
    vecs[12] = '{32'h0FF0000F, 3'd1, 64'h0000_0000_0000_00FF}; // fence
    vecs[13] = '{32'hFFF0809B, 3'd0, 64'h0000_0000_0000_0000}; // addiw: R
    vecs[14] = '{32'h000080E7, 3'd1, 64'h0000_0000_0000_0000}; // jalr 0

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state();
    rst = 1'b0;
    #1;
    chk("post_rst_rdy_a", 64'(rdy_a), 1);
    chk("post_rst_rdy_b", 64'(rdy_b), 1);

    // Back-to-back vectors with out_ready held high: each result appears
    // one edge after it is accepted and is taken downstream at the next.
    nill = 0;
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_tag   = 5'(i);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ov", i),    64'(ov_b), 1);
      chk($sformatf("v%0d_imm_a", i), 64'(imm_a), 64'(vecs[i].imm[31:0]));
      chk($sformatf("v%0d_imm_b", i), imm_b, vecs[i].imm);
      chk($sformatf("v%0d_fmt_a", i), 64'(fmt_a), 64'(vecs[i].fmt));
      chk($sformatf("v%0d_fmt_b", i), 64'(fmt_b), 64'(vecs[i].fmt));
      chk($sformatf("v%0d_tag", i),   64'(tag_a), 64'(i));
      chk($sformatf("v%0d_cnt_a", i), 64'(cnt_a), 64'(nill));
      chk($sformatf("v%0d_cnt_b", i), 64'(cnt_b), 64'((nill > 3) ? 3 : nill));
      if (vecs[i].fmt == 3'd7) nill++;
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("tbl_end_ov", 64'(ov_a), 0);
    chk("tbl_end_cnt_a", 64'(cnt_a), 64'(nill));
    chk("tbl_end_cnt_b", 64'(cnt_b), 3);

    // Reset pulse, then five illegal instructions: the 2-bit counter sticks at 3.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_state();
    in_valid = 1'b1; in_instr = 32'h00000000;
    for (int i = 0; i < 5; i++) begin
      in_tag = 5'(i);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("sat_cnt_a", 64'(cnt_a), 5);
    chk("sat_cnt_b", 64'(cnt_b), 3);

    // Reset while an instruction is held in the output stage.
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00000000; in_tag = 5'd9;
    @(posedge clk);
    #1;
    chk("mid_held_ov", 64'(ov_b), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_state();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("mid_rdy_a", 64'(rdy_a), 1);
    chk("mid_rdy_b", 64'(rdy_b), 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_discard_ov", 64'(ov_a), 0);

    // Random backpressure, then sustained full throughput.
    drain();
    stream(1'b1, cyc);
    drain();
    stream(1'b0, cyc);
    chk("full_rate_cycles", 64'(cyc), 9);

    // Stalled output: count how many instructions are accepted before in_ready drops.
    drain();
    out_ready = 1'b0; in_valid = 1'b1;
    n = 0;
    in_tag = 5'd0; in_instr = vecs[0].instr;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      fire = rdy_b;
      @(posedge clk);
      #1;
      if (fire) n++;
      in_tag = 5'(n); in_instr = vecs[n].instr;
    end
    chk("stall_accepts", 64'(n), 64'(EXP_ACC));
    chk("stall_rdy_b", 64'(rdy_b), 0);
    in_valid = 1'b0; out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ov_b) begin
        chk("release_tag", 64'(tag_b), 64'(got));
        chk("release_imm", imm_b, vecs[got].imm);
        got++;
      end
    end
    chk("release_count", 64'(got), 64'(EXP_ACC));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32_imm_gen_pipe.md
RV32_IMM_GEN_PIPE -- requirements
Module: rv32_imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32 or 64.
REQ-002 SHALL have parameter TAG_W, default 5, width of the sideband tag carried with each instruction.
REQ-003 SHALL have parameter CNT_W, default 16, width of the illegal-instruction counter.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  in_instr/in_tag valid.
REQ-007 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-008 SHALL have port in_instr  input  32  raw RV32 instruction.
REQ-009 SHALL have port in_tag  input  TAG_W  opaque sideband, passed through unchanged.
REQ-010 SHALL have port out_valid  output  1  out_* fields valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts output.
REQ-012 SHALL have port out_imm  output  XLEN  decoded immediate.
REQ-013 SHALL have port out_fmt  output  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 illegal.
REQ-014 SHALL have port out_tag  output  TAG_W  tag of the instruction on out_*.
REQ-015 SHALL have port illegal_cnt  output  CNT_W  count of format-7 instructions delivered.

Function
REQ-016 Transfer SHALL occur on an input when in_valid&&in_ready, and on an output when out_valid&&out_ready.
REQ-017 Opcodes 1100111, 0000011, 0010011, 0001111 SHALL decode as I: sign-extended instr[31:20].
REQ-018 Opcode 1110011 SHALL decode as Z: zero-extended instr[19:15].
REQ-019 Opcode 0100011 SHALL decode as S: sign-extended {instr[31:25],instr[11:7]}.
REQ-020 Opcode 1100011 SHALL decode as B: sign-extended {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}.
REQ-021 Opcodes 0110111, 0010111 SHALL decode as U: {instr[31:12],12'b0}, sign-extended to XLEN.
REQ-022 Opcode 1101111 SHALL decode as J: sign-extended {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}.
REQ-023 Opcodes 0110011, 0111011, 0011011 SHALL decode as R: out_imm = 0.
REQ-024 Any other opcode, or instr[1:0] != 2'b11, SHALL decode as illegal (fmt 7) with out_imm = I-format sign extension.
REQ-025 All sign extension SHALL replicate instr[31] up to XLEN bits.
REQ-026 Latency SHALL be exactly 1 cycle: input accepted at edge N appears on out_* after edge N.
REQ-027 Base mode: single output register; in_ready = !out_valid || out_ready (combinational).
REQ-028 out_* SHALL hold stable while out_valid && !out_ready.
REQ-029 Simultaneous input and output transfer SHALL replace the register contents with no bubble (full throughput).
REQ-030 illegal_cnt SHALL increment by 1 on each output transfer with out_fmt = 7, saturating at all ones.
REQ-031 Instructions SHALL leave in acceptance order; none dropped or duplicated.

Reset
REQ-032 While rst is high at a clock edge: out_valid = 0, out_imm = 0, out_fmt = 0, out_tag = 0, illegal_cnt = 0, skid storage empty.
REQ-033 Reset mid-transfer SHALL discard all in-flight instructions; in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-034 Macro PITO_IMM_SKID_EN SHALL select the buffering mode.
REQ-035 Defined: in_ready SHALL be a register output (no combinational path from out_ready); a 2-entry skid buffer SHALL absorb the in-flight instruction; in_ready = 0 only when both entries are full; throughput SHALL remain 1 per cycle.
REQ-036 Undefined: base mode per REQ-027; no skid storage.

Verification
REQ-037 XLEN=32, in 0xFFF00093 (addi -1) -> next cycle out_imm 0xFFFFFFFF, out_fmt 1.
REQ-038 XLEN=64, in 0x800000B7 (lui) -> out_imm 0xFFFFFFFF80000000, fmt 4; in 0xFE000EE3 (beq -4) -> out_imm 0xFFFFFFFFFFFFFFFC, fmt 3.
REQ-039 In 0x3402D073 (csrrwi zimm 5) -> out_imm 0x00000005, fmt 6; in 0x00000000 -> fmt 7, illegal_cnt increments to 1.
REQ-040 Stream 8 tagged instructions, out_ready toggled randomly -> tags 0..7 emerged in order, out_* stable while stalled, one per cycle when out_ready held 1.
REQ-041 PITO_IMM_SKID_EN defined, out_ready held 0 -> in_ready falls after exactly 2 accepts; release -> both delivered in order.
REQ-042 CNT_W=2, 5 illegal instructions -> illegal_cnt saturates at 3; rst pulse mid-stream -> out_valid 0, illegal_cnt 0.
